// File: rtl/sayac_pkg.sv
// Shared encodings for the SAYAC multiply/divide unit.
package sayac_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/sayac_mul_div_reg.sv
// Loadable register with asynchronous active-high clear; holds results between operations.
module sayac_mul_div_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sayac_mul_div.sv
// Sequential unsigned multiplier (shift-add) and restoring divider, one bit per cycle.
module sayac_mul_div
    import sayac_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         dz
);

    localparam int unsigned CntW = $clog2(N) + 1;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    opnd_q, opnd_d;
    logic            op_q, op_d;
    logic            dz_q, dz_d;

    logic [N:0]      mul_sum;
    logic [2*N-1:0]  mul_next;
    logic [N:0]      div_shift;
    logic [N:0]      div_diff;
    logic [2*N-1:0]  div_next;

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[N-1:1]};
        div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[N] ? {div_shift[N-1:0], acc_q[N-2:0], 1'b0}
                                : {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= OP_MUL;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = '0;
                    op_d  = op;
                    dz_d  = 1'b0;
                    if (op == OP_DIV) begin
                        opnd_d = b;
                        if (b == '0) begin
                            // Divide-by-zero bypasses CALC with the fixed result pattern
                            acc_d   = {a, {N{1'b1}}};
                            dz_d    = 1'b1;
                            state_d = StDone;
                        end else begin
                            acc_d   = {{N{1'b0}}, a};
                            state_d = StCalc;
                        end
                    end else begin
                        opnd_d  = a;
                        acc_d   = {{N{1'b0}}, b};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = (op_q == OP_DIV) ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q == StCalc) || (state_q == StDone);
    assign done = (state_q == StDone);

    sayac_mul_div_reg #(.W(N)) u_hi_reg (
        .clk (clk),
        .rst (rst),
        .ld  (done),
        .d   (acc_q[2*N-1:N]),
        .q   (hi)
    );

    sayac_mul_div_reg #(.W(N)) u_lo_reg (
        .clk (clk),
        .rst (rst),
        .ld  (done),
        .d   (acc_q[N-1:0]),
        .q   (lo)
    );

    sayac_mul_div_reg #(.W(1)) u_dz_reg (
        .clk (clk),
        .rst (rst),
        .ld  (done),
        .d   (dz_q),
        .q   (dz)
    );

endmodule

// File: doc/sayac_mul_div.md
SAYAC_MUL_DIV -- requirements
Module: sayac_mul_div

Interface
REQ-001 Parameter N, default 16, operand and result width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 op  input  1  0 = MUL (unsigned), 1 = DIV (unsigned).
REQ-006 a  input  N  multiplicand / dividend; captured when start is accepted.
REQ-007 b  input  N  multiplier / divisor; captured when start is accepted.
REQ-008 busy  output  1  high in CALC and DONE states.
REQ-009 done  output  1  one-cycle pulse; drives ld of the downstream result REG pair.
REQ-010 hi  output  N  MUL: product[2N-1:N]; DIV: remainder.
REQ-011 lo  output  N  MUL: product[N-1:0]; DIV: quotient.
REQ-012 dz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 FSM states IDLE, CALC, DONE; IDLE -> CALC on start; CALC -> DONE after N iterations; DONE -> IDLE unconditionally.
REQ-014 Start accepted only in IDLE; a, b, op latched on that edge; start during CALC/DONE ignored, no queuing.
REQ-015 MUL: shift-add, one multiplier bit per CALC cycle, LSB first, 2N-bit accumulator, no overflow possible.
REQ-016 DIV: restoring shift-subtract, one quotient bit per CALC cycle, MSB first.
REQ-017 Iteration counter, log2(N)+1 bits, cleared on start acceptance; CALC exits when count reaches N-1.
REQ-018 Latency: start sampled at edge E0 -> CALC for N cycles -> done high for exactly one cycle after edge E(N+1) (E17 for N=16).
REQ-019 hi, lo, dz update only on the edge ending DONE, i.e. the edge on which done is sampled high by the downstream REG; between operations they hold their values.
REQ-020 DIV with b = 0: skip CALC, IDLE -> DONE next edge; lo = all ones, hi = a, dz = 1; done asserts after edge E1.
REQ-021 dz = 0 for every MUL and for DIV with b != 0.
REQ-022 Back-to-back: start high in the cycle after done is accepted (IDLE); no dead cycle beyond the DONE state.
REQ-023 Operand inputs may change freely after acceptance without affecting the result.

Reset
REQ-024 rst high: state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, dz = 0, counter and accumulators = 0, immediately, clock-independent.
REQ-025 rst during CALC/DONE aborts the operation; no done pulse is produced for it; first start after rst release is accepted normally.

Structure
REQ-026 Shared package/header sayac_pkg holds the op encodings (OP_MUL = 0, OP_DIV = 1) and FSM state encodings.
REQ-027 hi/lo/dz result holding uses the existing REG module (N-bit instances, ld = internal done-capture enable, same clk/rst).
REQ-028 The datapath (accumulator, shifter, subtractor) and FSM stay in sayac_mul_div; no further sub-modules.

Verification
REQ-029 MUL a = 0x1234, b = 0x0010 -> done after E17, hi = 0x0001, lo = 0x2340, dz = 0.
REQ-030 MUL a = 0xFFFF, b = 0xFFFF -> hi = 0xFFFE, lo = 0x0001.
REQ-031 DIV a = 0x0064, b = 0x0007 -> lo = 0x000E, hi = 0x0002, dz = 0, done after E17.
REQ-032 DIV a = 0xABCD, b = 0 -> done after E1, lo = 0xFFFF, hi = 0xABCD, dz = 1.
REQ-033 start pulsed again at cycle 5 of a MUL -> ignored, single done, result equals the first operation.
REQ-034 rst asserted at cycle 8 of a DIV -> all outputs 0 at once, no done; new MUL 3 x 5 -> lo = 0x000F, hi = 0.
